gate_resp_checker: RTL
======================

GATE_RESP_CHECKER -- requirements
Module: gate_resp_checker

Interface
REQ-001 Parameter GATE_OP, default 0, selects the expected 2-input function: 0=AND, 1=OR, 2=XOR, 3=NAND, 4=NOR, 5=XNOR.
REQ-002 Parameter CNT_W, default 8, sets the width of the pass and fail counters.
REQ-003 clk  input  1  the only clock; all logic SHALL be rising-edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins or restarts a check run.
REQ-006 in_valid  input  1  marks a, b and y as a sample to check this cycle.
REQ-007 a, b  input  1 each  gate inputs as driven to the DUT.
REQ-008 y  input  1  gate output as observed from the DUT.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  high in DONE.
REQ-011 error  output  1  sticky high once any mismatch is seen in the current run.
REQ-012 pass_cnt, fail_cnt  output  CNT_W each  count of matching and mismatching samples.
REQ-013 cov_mask  output  4  bit {a,b} set once that input combination has been sampled.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE when cov_mask reaches 4'b1111.
- DONE->RUN on start.
REQ-015 On entry to RUN, pass_cnt, fail_cnt, cov_mask and error SHALL be cleared in the same edge as the state change.
REQ-016 In RUN, when in_valid=1, expected = f_GATE_OP(a,b).
- y==expected: pass_cnt increments.
- Otherwise: fail_cnt increments and error is set.
- Outputs SHALL update on the following clock edge (latency 1).
REQ-017 Each RUN sample with in_valid=1 SHALL set cov_mask[{a,b}].
REQ-018 The RUN->DONE transition SHALL be evaluated on the updated mask, so the sample that completes coverage is counted and done asserts on the same edge.
REQ-019 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 in_valid in IDLE or DONE SHALL be ignored; all outputs are held.
REQ-021 start in RUN SHALL be ignored.
REQ-022 start and in_valid together in IDLE or DONE: start wins, and the sample is not counted.
REQ-023 Any y other than 0 or 1 (X or Z) SHALL count as a mismatch.

Reset
REQ-024 While rst_n=0 at a clock edge, the block SHALL clear state to IDLE and all outputs to 0, including during RUN; no sample is counted on that edge.

Configuration
REQ-025 Macro GATE_CHK_FIRST_FAIL_EN.
- Defined: the block adds output first_fail_vec[2:0] = {a,b,y}, captured on the first mismatch of a run, held until the next run start or reset, reset value 0.
- Undefined: the port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-026 The GATE_OP encodings, the FSM state encodings and the function-evaluation helper SHALL live in shared package gate_chk_pkg.
REQ-027 Coverage and saturation counting SHALL be one sub-module, gate_cov_tracker; the FSM and comparison stay in gate_resp_checker.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- GATE_OP=0, start, then (a,b,y) = (0,0,0), (0,1,0), (1,0,0), (1,1,1) -> pass_cnt=4, fail_cnt=0, cov_mask=F, done=1 one edge after the 4th sample, error=0.
- Same sequence with (1,1,0) -> fail_cnt=1, pass_cnt=3, error=1, done=1; with the macro defined, first_fail_vec=3'b110.
- CNT_W=2, five samples of (0,1,0) -> pass_cnt=3 (saturated), cov_mask=0010, busy=1, done=0.
- rst_n=0 for one edge after two samples -> all outputs 0, IDLE; a subsequent in_valid is ignored.
- From DONE, start together with in_valid -> counters and mask 0, busy=1, sample not counted.
- GATE_OP=2, y=X on (1,0) -> fail_cnt=1, error=1.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - shared gate-op encodings, FSM states and gate evaluation helper
package gate_chk_pkg;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_XOR  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XNOR = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_t;

  function automatic logic gate_eval(input int op, input logic a, input logic b);
    logic r;
    case (op)
      GATE_AND:  r = a & b;
      GATE_OR:   r = a | b;
      GATE_XOR:  r = a ^ b;
      GATE_NAND: r = ~(a & b);
      GATE_NOR:  r = ~(a | b);
      GATE_XNOR: r = ~(a ^ b);
      default:   r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_cov_tracker.sv
// rtl/gate_cov_tracker.sv - input-combination coverage mask and saturating pass/fail counters
module gate_cov_tracker
  import gate_chk_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample,
  input  logic             match,
  input  logic [1:0]       sel,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       cov_mask,
  output logic [3:0]       cov_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Mask as it will look after this edge, so the caller can finish on the completing sample
  always_comb begin
    cov_next = cov_mask;
    if (sample) cov_next = cov_mask | (4'b0001 << sel);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      cov_mask <= 4'b0000;
    end else if (sample) begin
      cov_mask <= cov_next;
      if (match) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_resp_checker.sv
// rtl/gate_resp_checker.sv - checks observed gate output against GATE_OP and tracks coverage
// Optional first_fail_vec capture enabled by macro GATE_CHK_FIRST_FAIL_EN.
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int GATE_OP = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       cov_mask
`ifdef GATE_CHK_FIRST_FAIL_EN
  ,
  output logic [2:0]       first_fail_vec
`endif
);

  chk_state_t state_q, state_d;
  logic       run_clear;
  logic       sample;
  logic       match;
  logic       exp_y;
  logic [3:0] cov_next;

  // An X/Z on y makes the equality unknown, which falls through to a mismatch
  always_comb begin
    exp_y = gate_eval(GATE_OP, a, b);
    match = 1'b0;
    if (y == exp_y) match = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    run_clear = 1'b0;
    sample    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          run_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          sample = 1'b1;
          if (cov_next == 4'b1111) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || run_clear)   error <= 1'b0;
    else if (sample && !match) error <= 1'b1;
  end

`ifdef GATE_CHK_FIRST_FAIL_EN
  always_ff @(posedge clk) begin
    if (!rst_n || run_clear)             first_fail_vec <= 3'b000;
    else if (sample && !match && !error) first_fail_vec <= {a, b, y};
  end
`endif

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  gate_cov_tracker #(.CNT_W(CNT_W)) u_cov (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (run_clear),
    .sample   (sample),
    .match    (match),
    .sel      ({a, b}),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt),
    .cov_mask (cov_mask),
    .cov_next (cov_next)
  );

endmodule
